tia_hsync_poly: RTL and testbench

Horizontal polynomial counter for the TIA core: a 6-bit XNOR LFSR that steps once per biphase cycle and cycles through 57 states, giving 228 `clk` periods per scan line. It generates its own phi1/phi2 phase strobes from `clk`, so the downstream d1/d2 latch chain gets the same two-phase timing that drives this counter. It also exposes the raw count, a line-end decode, and a wrap pulse for the horizontal decode logic.

---
 rtl/tia_hsync_poly_if.sv | 21 ++
 rtl/tia_hsync_poly.sv | 76 +++++++
 tb/tb_tia_hsync_poly.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tia_hsync_poly_if.sv
// tia_hsync_poly_if
// Bundles the horizontal-sync request and the counter's decode outputs.
//   hrs  : horizontal reset request (RSYNC strobe), toward the counter
//   cnt  : 6-bit LFSR state, cnt[5] is the MSB
//   phi1 : phase-1 strobe, high one clk in four
//   phi2 : phase-2 strobe, high one clk in four
//   shb  : line-end decode, high while cnt is the terminal state
//   wrap : one-clk pulse following a natural terminal-to-zero wrap
// The counter connects through the slave modport; the requester/observer
// connects through the master modport.
interface tia_hsync_poly_if;
    logic       hrs;
    logic [5:0] cnt;
    logic       phi1;
    logic       phi2;
    logic       shb;
    logic       wrap;

    modport slave  (input  hrs, output cnt, phi1, phi2, shb, wrap);
    modport master (output hrs, input  cnt, phi1, phi2, shb, wrap);
endinterface

// File: rtl/tia_hsync_poly.sv
// tia_hsync_poly
// Horizontal polynomial counter for the TIA core. A free-running 2-bit phase
// counter splits clk into four-clk biphase cycles and produces phi1/phi2. A
// 6-bit XNOR LFSR advances once per biphase cycle through 57 states, so one
// scan line is 57 * 4 = 228 clk.
// Ports:
//   clk : colour clock, all state changes on its rising edge
//   r   : synchronous active-high reset
//   bus : tia_hsync_poly_if.slave (hrs in; cnt, phi1, phi2, shb, wrap out)
module tia_hsync_poly (
    input  logic               clk,
    input  logic               r,
    tia_hsync_poly_if.slave    bus
);

    localparam logic [5:0] CNT_TERM = 6'b001010;  // state 56, last in the line
    localparam logic [5:0] CNT_LOCK = 6'b111111;  // XNOR lockup fixed point

    logic [1:0] ph_r;
    logic [5:0] cnt_r;
    logic       hp_r;
    logic       wrap_r;
    logic       adv_s;

    // XNOR feedback step: shift left, feed back ~(b5 ^ b4).
    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        return {v[4:0], ~(v[5] ^ v[4])};
    endfunction

    // The counter moves on the edge that takes the phase from 3 back to 0.
    assign adv_s = (ph_r == 2'd3);

    // Phase counter, LFSR, pending horizontal reset and wrap pulse.
    always_ff @(posedge clk) begin
        if (r) begin
            ph_r   <= 2'd0;
            cnt_r  <= 6'd0;
            hp_r   <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            ph_r   <= ph_r + 2'd1;
            wrap_r <= 1'b0;
            if (adv_s) begin
                // A request seen on this very edge is consumed here too,
                // so the pending flag always clears on an advance.
                hp_r <= 1'b0;
                if (hp_r || bus.hrs) begin
                    cnt_r <= 6'd0;
                end else if (cnt_r == CNT_TERM) begin
                    cnt_r  <= 6'd0;
                    wrap_r <= 1'b1;
                end else if (cnt_r == CNT_LOCK) begin
                    cnt_r <= 6'd0;
                end else begin
                    cnt_r <= lfsr_step(cnt_r);
                end
            end else begin
                if (bus.hrs) begin
                    hp_r <= 1'b1;
                end else begin
                    hp_r <= hp_r;
                end
                cnt_r <= cnt_r;
            end
        end
    end

    // Strobes and line-end are plain decodes of the state registers so they
    // line up exactly with the phase/count they describe.
    assign bus.cnt  = cnt_r;
    assign bus.phi1 = (ph_r == 2'd1);
    assign bus.phi2 = (ph_r == 2'd3);
    assign bus.shb  = (cnt_r == CNT_TERM);
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_tia_hsync_poly.sv
// Testbench for tia_hsync_poly: directed scenarios plus randomized hrs/r
// traffic, all checked against a line-position reference model.
module tb_tia_hsync_poly;

    logic clk;
    logic r;
    tia_hsync_poly_if bus ();

    tia_hsync_poly dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int fails     = 0;

    // Reference model: position within the biphase cycle, index along the
    // 57-entry sequence, plus lockup/pending/wrap flags.
    logic [5:0] seq [0:56];
    int   m_p;
    int   m_idx;
    bit   m_lock;
    bit   m_pend;
    bit   m_wrap;
    int   edge_n;

    function automatic logic [9:0] exp_vec();
        logic [5:0] c;
        c = m_lock ? 6'h3f : seq[m_idx];
        return {c, (m_p == 1), (m_p == 3), (!m_lock && m_idx == 56), m_wrap};
    endfunction

    function automatic logic [9:0] act_vec();
        return {bus.cnt, bus.phi1, bus.phi2, bus.shb, bus.wrap};
    endfunction

    task automatic tick(input logic rv, input logic hv);
        bit adv;
        r       = rv;
        bus.hrs = hv;
        @(posedge clk);
        if (rv) begin
            m_p = 0; m_idx = 0; m_lock = 0; m_pend = 0; m_wrap = 0; edge_n = 0;
        end else begin
            adv    = (m_p == 3);
            m_p    = (m_p + 1) % 4;
            m_wrap = 0;
            edge_n++;
            if (adv) begin
                if (m_pend || hv) begin
                    m_idx = 0; m_lock = 0;
                end else if (m_lock) begin
                    m_idx = 0; m_lock = 0;
                end else if (m_idx == 56) begin
                    m_idx = 0; m_wrap = 1;
                end else begin
                    m_idx++;
                end
                m_pend = 0;
            end else if (hv) begin
                m_pend = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            tests_run++;
            if (act_vec() !== 10'd0) begin
                fails++; $display("FAIL reset_init: got %b exp %b", act_vec(), 10'd0);
            end
        end
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, (i == 1));
            tests_run++;
            if (act_vec() !== 10'd0) begin
                fails++; $display("FAIL reset_mid: got %b exp %b", act_vec(), 10'd0);
            end
        end
        for (int e = 1; e <= 4; e++) begin
            tick(1'b0, 1'b0);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_release e%0d: got %b exp %b", e, act_vec(), exp_vec());
            end
            tests_run++;
            if (bus.phi1 !== (e == 1) || bus.phi2 !== (e == 3) || bus.cnt !== ((e == 4) ? 6'd1 : 6'd0)) begin
                fails++; $display("FAIL reset_edges e%0d: phi1=%b phi2=%b cnt=%b", e, bus.phi1, bus.phi2, bus.cnt);
            end
        end
    endtask

    task automatic test_free_run();
        logic [5:0] want;
        tick(1'b1, 1'b0);
        for (int e = 1; e <= 500; e++) begin
            tick(1'b0, 1'b0);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL free_run e%0d: got %b exp %b", e, act_vec(), exp_vec());
            end
            tests_run++;
            if (bus.wrap !== (e == 228 || e == 456)) begin
                fails++; $display("FAIL free_wrap e%0d: got %b", e, bus.wrap);
            end
            if (e == 20 || e == 80 || e == 224 || e == 228) begin
                case (e)
                    20:      want = 6'b011111;
                    80:      want = 6'b101011;
                    224:     want = 6'b001010;
                    default: want = 6'b000000;
                endcase
                tests_run++;
                if (bus.cnt !== want) begin
                    fails++; $display("FAIL free_key e%0d: got %b exp %b", e, bus.cnt, want);
                end
            end
        end
    endtask

    task automatic test_hrs_pulse();
        tick(1'b1, 1'b0);
        for (int e = 1; e <= 270; e++) begin
            tick(1'b0, (e == 41));
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL hrs_pulse e%0d: got %b exp %b", e, act_vec(), exp_vec());
            end
            if (e == 44 || e == 268) begin
                tests_run++;
                if (bus.cnt !== ((e == 44) ? 6'd0 : 6'b001010) || bus.wrap !== 1'b0) begin
                    fails++; $display("FAIL hrs_key e%0d: cnt=%b wrap=%b", e, bus.cnt, bus.wrap);
                end
            end
        end
    endtask

    task automatic test_hrs_terminal();
        for (int v = 0; v < 2; v++) begin
            tick(1'b1, 1'b0);
            for (int e = 1; e <= 232; e++) begin
                tick(1'b0, (e == 227 + v));
                tests_run++;
                if (act_vec() !== exp_vec()) begin
                    fails++; $display("FAIL hrs_term v%0d e%0d: got %b exp %b", v, e, act_vec(), exp_vec());
                end
                if (e == 228) begin
                    tests_run++;
                    if (bus.cnt !== 6'd0 || bus.wrap !== 1'b0) begin
                        fails++; $display("FAIL hrs_term_key v%0d: cnt=%b wrap=%b", v, bus.cnt, bus.wrap);
                    end
                end
            end
        end
    endtask

    task automatic test_lockup();
        tick(1'b1, 1'b0);
        for (int e = 1; e <= 30; e++) tick(1'b0, 1'b0);
        force dut.cnt_r = 6'h3f;
        #1;
        release dut.cnt_r;
        m_lock = 1;
        for (int e = 31; e <= 262; e++) begin
            tick(1'b0, 1'b0);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL lockup e%0d: got %b exp %b", e, act_vec(), exp_vec());
            end
            if (e == 32 || e == 256 || e == 260) begin
                tests_run++;
                if (bus.cnt !== ((e == 256) ? 6'b001010 : 6'd0) || bus.wrap !== (e == 260)) begin
                    fails++; $display("FAIL lockup_key e%0d: cnt=%b wrap=%b", e, bus.cnt, bus.wrap);
                end
            end
        end
    endtask

    task automatic test_reset_on_advance();
        tick(1'b1, 1'b0);
        for (int e = 1; e <= 39; e++) tick(1'b0, (e >= 38));
        tick(1'b1, 1'b1);
        tests_run++;
        if (bus.cnt !== 6'd0 || dut.ph_r !== 2'd0 || dut.hp_r !== 1'b0 || bus.wrap !== 1'b0) begin
            fails++; $display("FAIL rst_adv: cnt=%b ph=%b hp=%b wrap=%b", bus.cnt, dut.ph_r, dut.hp_r, bus.wrap);
        end
        for (int e = 1; e <= 4; e++) begin
            tick(1'b0, 1'b0);
            tests_run++;
            if (bus.cnt !== ((e == 4) ? 6'd1 : 6'd0) || act_vec() !== exp_vec()) begin
                fails++; $display("FAIL rst_adv_rel e%0d: got %b exp %b", e, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic rv;
        logic hv;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 199) == 0);
            hv = ($urandom_range(0, 15) == 0);
            tick(rv, hv);
            tests_run++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL random i%0d: got %b exp %b", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        logic [5:0] v;
        v = 6'd0;
        for (int k = 0; k < 57; k++) begin
            seq[k] = v;
            v = {v[4:0], ~(v[5] ^ v[4])};
        end
        m_p = 0; m_idx = 0; m_lock = 0; m_pend = 0; m_wrap = 0; edge_n = 0;
        r = 1'b1;
        bus.hrs = 1'b0;
        test_reset();
        test_free_run();
        test_hrs_pulse();
        test_hrs_terminal();
        test_lockup();
        test_reset_on_advance();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
